config_sequencer: RTL and testbench
===================================

Name: config_sequencer

Overview:
Parametrised serial register-configuration sequencer that replaces hard-coded init lookups. It holds a runtime-writable table of DATA_WIDTH-bit command words. On Start it streams a selectable contiguous range of the table to a 16-bit-style serial master (I2C/3-wire) through a start/done/ack handshake. It adds per-entry NACK retry, an inter-transfer gap, abort, and error reporting, and sits between the top-level init FSM and the serial master unit.

Parameters:
DATA_WIDTH, 16, width of one table entry / serial command word
NUM_ENTRIES, 20, table depth
ADDR_WIDTH, 5, index width; must satisfy 2**ADDR_WIDTH >= NUM_ENTRIES
MAX_RETRIES, 3, re-sends per entry after NACK; 0 = no retry
GAP_CYCLES, 0, idle clocks between consecutive transfers (16-bit counter)

Ports:
Clock  in  1  system clock, all logic on posedge
Resetn  in  1  asynchronous active-low reset
Start  in  1  begin sequence; sampled only when Done=1
Start_index  in  ADDR_WIDTH  first table entry to send
Count  in  ADDR_WIDTH+1  number of entries to send
Abort  in  1  stop sequence; ignored when idle
Done  out  1  high when idle/finished
Err_code  out  2  00 ok, 01 NACK retries exhausted, 10 bad range, 11 aborted
Error_index  out  ADDR_WIDTH  entry index at which the error occurred
Cur_index  out  ADDR_WIDTH  entry currently being sent
Tbl_we  in  1  table write enable
Tbl_addr  in  ADDR_WIDTH  table write address
Tbl_wdata  in  DATA_WIDTH  table write data
Ser_start  out  1  one-cycle start pulse to the serial master
Ser_data  out  DATA_WIDTH  word to send; held stable until completion
Ser_ack  in  1  master acknowledge; valid when Ser_done rises
Ser_done  in  1  master idle level (high = idle)

Behaviour:
- Reset values:
  - Done=1, Err_code=00, Error_index=0, Cur_index=0, Ser_start=0, Ser_data=0.
  - All table entries = 0.
  - FSM in IDLE; retry and gap counters = 0.
- Table writes:
  - Accepted only when Done=1 and Tbl_addr<NUM_ENTRIES; otherwise ignored.
  - A write takes effect in the same cycle it is sampled.
  - Tbl_we together with Start in IDLE: the new value is visible to the sequence.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE, Start=1:
  - Range check first. Count=0, or Start_index>=NUM_ENTRIES, or Start_index+Count>NUM_ENTRIES: stay IDLE, Done stays 1, Err_code=10, Error_index=Start_index, no Ser_start.
  - Valid range: Done<=0, Err_code<=00, Cur_index<=Start_index, remaining<=Count, retry<=0, go to ISSUE.
- ISSUE:
  - Ser_data<=table[Cur_index], Ser_start<=1 for exactly one cycle, go to WAIT_BUSY.
  - Ser_start is high 2 cycles after the Start sample.
- WAIT_BUSY: wait for Ser_done=0 (master accepted), then go to WAIT_DONE. Ser_done is never treated as completion in the Ser_start cycle.
- WAIT_DONE, on Ser_done=1, sample Ser_ack:
  - ACK with remaining=1: Done<=1, Err_code=00, go to IDLE.
  - ACK with remaining>1: remaining--, Cur_index++, retry<=0, go to GAP.
  - NACK with retry<MAX_RETRIES: retry++, Cur_index unchanged, go to GAP.
  - NACK with retry=MAX_RETRIES: Err_code=01, Error_index=Cur_index, Done<=1, go to IDLE.
- GAP:
  - Count GAP_CYCLES clocks, then go to ISSUE.
  - GAP_CYCLES=0 goes straight to ISSUE the next cycle.
- Abort:
  - In ISSUE or GAP: next state IDLE, Done=1, Err_code=11, Error_index=Cur_index, no further Ser_start.
  - In WAIT_BUSY or WAIT_DONE: latched. The in-flight frame completes, its result is discarded, then the same abort exit is taken.
- Start while Done=0 is ignored.
- Start and Abort together in IDLE: Start is accepted and Abort is ignored.
- Ser_data keeps its last value when idle.
- Reset mid-sequence aborts immediately to reset values. The table is cleared.

Test Plan:
- Load entries 0..3 = 16'h4501,4502,4503,4504; Start_index=0, Count=4; model ACKs with 10-cycle busy → four Ser_start pulses carrying 4501..4504 in order; Done=1, Err_code=00 after the 4th Ser_done rise; Ser_start exactly 2 cycles after Start.
- GAP_CYCLES=5 → exactly 5 idle cycles between each Ser_done rise+1 and the next ISSUE.
- MAX_RETRIES=3; entry 2 NACKs twice then ACKs → entry 2 sent 3 times; sequence completes, Err_code=00. Entry 2 always NACKs → 4 sends, Err_code=01, Error_index=2, entry 3 never sent.
- Start_index=18, Count=3 with NUM_ENTRIES=20 → no Ser_start, Err_code=10, Error_index=18, Done stays 1. Count=0 → same with Err_code=10.
- Abort during WAIT_DONE of entry 1 (of 4) → frame completes, no further Ser_start, Err_code=11, Error_index=1. Abort during GAP → stops next cycle.
- Resetn low during WAIT_DONE → outputs at reset values immediately. Tbl_we while Done=0 → table unchanged on readback via a later sequence.

Source files
------------

// File: rtl/config_sequencer.sv
// Runtime-writable command table streamed, entry by entry, to a serial master
// through a start/done/ack handshake, with NACK retry, inter-frame gap and abort.
module config_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_ENTRIES = 20,
  parameter int ADDR_WIDTH  = 5,
  parameter int MAX_RETRIES = 3,
  parameter int GAP_CYCLES  = 0
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] Start_index,
  input  logic [ADDR_WIDTH:0]   Count,
  input  logic                  Abort,
  output logic                  Done,
  output logic [1:0]            Err_code,
  output logic [ADDR_WIDTH-1:0] Error_index,
  output logic [ADDR_WIDTH-1:0] Cur_index,
  input  logic                  Tbl_we,
  input  logic [ADDR_WIDTH-1:0] Tbl_addr,
  input  logic [DATA_WIDTH-1:0] Tbl_wdata,
  output logic                  Ser_start,
  output logic [DATA_WIDTH-1:0] Ser_data,
  input  logic                  Ser_ack,
  input  logic                  Ser_done
);

  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [RW-1:0]         MAX_R = RW'(MAX_RETRIES);
  localparam logic [ADDR_WIDTH+1:0] LIM   = (ADDR_WIDTH + 2)'(NUM_ENTRIES);
  localparam logic [15:0]           GAP_N = 16'(GAP_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_GAP} state_t;
  typedef enum logic [1:0] {ERR_OK, ERR_NACK, ERR_RANGE, ERR_ABORT} err_t;

  state_t                  state_q, state_d;
  err_t                    err_q, err_d;
  logic                    done_q, done_d;
  logic [ADDR_WIDTH-1:0]   err_idx_q, err_idx_d;
  logic [ADDR_WIDTH-1:0]   cur_idx_q, cur_idx_d;
  logic [ADDR_WIDTH:0]     remaining_q, remaining_d;
  logic [RW-1:0]           retry_q, retry_d;
  logic [15:0]             gap_q, gap_d;
  logic                    abort_pend_q, abort_pend_d;
  logic                    ser_start_q, ser_start_d;
  logic [DATA_WIDTH-1:0]   ser_data_q, ser_data_d;
  logic [DATA_WIDTH-1:0]   tbl_q [NUM_ENTRIES];

  logic                    tbl_wr;
  logic                    range_bad;
  logic                    abort_exit;
  logic [ADDR_WIDTH+1:0]   range_end;

  assign tbl_wr    = Tbl_we && done_q && ({2'b00, Tbl_addr} < LIM);
  assign range_end = {2'b00, Start_index} + {1'b0, Count};
  assign range_bad = (Count == '0) || ({2'b00, Start_index} >= LIM) || (range_end > LIM);

  // NOTE: the table must read as all-zero after reset, so every entry is a
  // resettable flop rather than an inferred RAM without reset.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < NUM_ENTRIES; i++) tbl_q[i] <= '0;
    end else if (tbl_wr) begin
      tbl_q[Tbl_addr] <= Tbl_wdata;
    end
  end

  // NOTE: every always_comb target gets its hold value first; a path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    done_d       = done_q;
    err_idx_d    = err_idx_q;
    cur_idx_d    = cur_idx_q;
    remaining_d  = remaining_q;
    retry_d      = retry_q;
    gap_d        = gap_q;
    abort_pend_d = abort_pend_q;
    ser_start_d  = 1'b0;
    ser_data_d   = ser_data_q;
    abort_exit   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (range_bad) begin
            err_d     = ERR_RANGE;
            err_idx_d = Start_index;
          end else begin
            done_d       = 1'b0;
            err_d        = ERR_OK;
            cur_idx_d    = Start_index;
            remaining_d  = Count;
            retry_d      = '0;
            abort_pend_d = 1'b0;
            state_d      = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (Abort) begin
          abort_exit = 1'b1;
        end else begin
          ser_data_d  = tbl_q[cur_idx_q];
          ser_start_d = 1'b1;
          state_d     = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (Abort) abort_pend_d = 1'b1;
        if (!Ser_done) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (Abort) abort_pend_d = 1'b1;
        if (Ser_done) begin
          // A pending abort discards the result of the frame that just finished.
          if (abort_pend_q || Abort) begin
            abort_exit = 1'b1;
          end else if (Ser_ack) begin
            if (remaining_q == (ADDR_WIDTH + 1)'(1)) begin
              done_d  = 1'b1;
              err_d   = ERR_OK;
              state_d = S_IDLE;
            end else begin
              remaining_d = remaining_q - (ADDR_WIDTH + 1)'(1);
              cur_idx_d   = cur_idx_q + ADDR_WIDTH'(1);
              retry_d     = '0;
              gap_d       = '0;
              state_d     = S_GAP;
            end
          end else if (retry_q < MAX_R) begin
            retry_d = retry_q + RW'(1);
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            err_d     = ERR_NACK;
            err_idx_d = cur_idx_q;
            done_d    = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (Abort) begin
          abort_exit = 1'b1;
        end else if (gap_q >= GAP_N) begin
          state_d = S_ISSUE;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_exit) begin
      state_d      = S_IDLE;
      done_d       = 1'b1;
      err_d        = ERR_ABORT;
      err_idx_d    = cur_idx_q;
      abort_pend_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= S_IDLE;
      err_q        <= ERR_OK;
      done_q       <= 1'b1;
      err_idx_q    <= '0;
      cur_idx_q    <= '0;
      remaining_q  <= '0;
      retry_q      <= '0;
      gap_q        <= '0;
      abort_pend_q <= 1'b0;
      ser_start_q  <= 1'b0;
      ser_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      done_q       <= done_d;
      err_idx_q    <= err_idx_d;
      cur_idx_q    <= cur_idx_d;
      remaining_q  <= remaining_d;
      retry_q      <= retry_d;
      gap_q        <= gap_d;
      abort_pend_q <= abort_pend_d;
      ser_start_q  <= ser_start_d;
      ser_data_q   <= ser_data_d;
    end
  end

  assign Done        = done_q;
  assign Err_code    = err_q;
  assign Error_index = err_idx_q;
  assign Cur_index   = cur_idx_q;
  assign Ser_start   = ser_start_q;
  assign Ser_data    = ser_data_q;

endmodule

// File: tb/tb_config_sequencer.sv
// Scoreboard bench for config_sequencer: a behavioural serial master pops the
// expected frame for every Ser_start and answers ACK/NACK from the model plan.
module tb_config_sequencer;

  localparam int DW   = 16;
  localparam int NE   = 20;
  localparam int AW   = 5;
  localparam int MR   = 3;
  localparam int GAP  = 5;
  localparam int BUSY = 10;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] idx;
    logic          ack;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_index = '0;
  logic [AW:0]   count = '0;
  logic          abort = 1'b0;
  logic          done;
  logic [1:0]    err_code;
  logic [AW-1:0] error_index;
  logic [AW-1:0] cur_index;
  logic          tbl_we = 1'b0;
  logic [AW-1:0] tbl_addr = '0;
  logic [DW-1:0] tbl_wdata = '0;
  logic          ser_start;
  logic [DW-1:0] ser_data;
  logic          ser_ack = 1'b0;
  logic          ser_done = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int sends = 0, done_rises = 0, cyc = 0, rise_cyc = 0, busy_left = 0;
  bit rise_valid = 1'b0;
  logic cur_ack = 1'b1;
  logic [DW-1:0] model_tbl [NE];
  int nack_plan [NE];
  exp_t sb [$];

  config_sequencer #(
    .DATA_WIDTH(DW), .NUM_ENTRIES(NE), .ADDR_WIDTH(AW),
    .MAX_RETRIES(MR), .GAP_CYCLES(GAP)
  ) dut (
    .Clock(clk), .Resetn(rst_n), .Start(start), .Start_index(start_index),
    .Count(count), .Abort(abort), .Done(done), .Err_code(err_code),
    .Error_index(error_index), .Cur_index(cur_index), .Tbl_we(tbl_we),
    .Tbl_addr(tbl_addr), .Tbl_wdata(tbl_wdata), .Ser_start(ser_start),
    .Ser_data(ser_data), .Ser_ack(ser_ack), .Ser_done(ser_done)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Serial master model: accepts a frame on Ser_start, stays busy BUSY cycles.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ser_done = 1'b1; ser_ack = 1'b0; busy_left = 0; rise_valid = 1'b0;
      end else if (busy_left > 0) begin
        if (busy_left == BUSY) check("ser_start_width", ser_start, 0);
        busy_left--;
        if (busy_left == 0) begin
          ser_ack = cur_ack; ser_done = 1'b1;
          done_rises++; rise_cyc = cyc; rise_valid = 1'b1;
        end
      end else if (ser_start) begin
        sends++;
        if (rise_valid) check("gap_cycles", cyc - rise_cyc, GAP + 3);
        check("send_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("ser_data", ser_data, e.data);
          check("cur_index", cur_index, e.idx);
          cur_ack = e.ack;
        end else begin
          cur_ack = 1'b1;
        end
        ser_done = 1'b0; busy_left = BUSY;
      end
    end
  end

  function automatic void push_exp(input int i, input logic ack);
    exp_t e;
    e.data = model_tbl[i]; e.idx = AW'(i); e.ack = ack;
    sb.push_back(e);
  endfunction

  task automatic plan_seq(input int si, input int cnt, output int e_err, output int e_idx);
    int k;
    e_err = 0; e_idx = 0;
    if (cnt == 0 || si >= NE || si + cnt > NE) begin
      e_err = 2; e_idx = si;
      return;
    end
    for (int i = si; i < si + cnt; i++) begin
      k = nack_plan[i];
      if (k > MR) begin
        for (int r = 0; r <= MR; r++) push_exp(i, 1'b0);
        e_err = 1; e_idx = i;
        return;
      end
      for (int r = 0; r < k; r++) push_exp(i, 1'b0);
      push_exp(i, 1'b1);
    end
  endtask

  task automatic pulse_start(input int si, input int cnt, input logic abrt,
                             input logic we, input int wa, input logic [DW-1:0] wd);
    @(negedge clk);
    start = 1'b1; start_index = AW'(si); count = (AW + 1)'(cnt); abort = abrt;
    tbl_we = we; tbl_addr = AW'(wa); tbl_wdata = wd; rise_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; tbl_we = 1'b0;
  endtask

  task automatic write_tbl(input int addr, input logic [DW-1:0] data);
    @(negedge clk);
    tbl_we = 1'b1; tbl_addr = AW'(addr); tbl_wdata = data;
    @(negedge clk);
    tbl_we = 1'b0;
    if (addr < NE) model_tbl[addr] = data;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 2000 && done !== 1'b1; i++) @(negedge clk);
    check({tag, "_done"}, done, 1);
  endtask

  task automatic wait_sends(input int target, input string tag);
    for (int i = 0; i < 500 && sends < target; i++) @(posedge clk);
    check({tag, "_reach_send"}, sends >= target, 1);
  endtask

  task automatic finish_checks(input string tag, input int e_err, input int e_idx);
    check({tag, "_err"}, err_code, e_err);
    if (e_err != 0) check({tag, "_err_idx"}, error_index, e_idx);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic run_seq(input string tag, input int si, input int cnt);
    int e_err, e_idx;
    plan_seq(si, cnt, e_err, e_idx);
    pulse_start(si, cnt, 1'b0, 1'b0, 0, '0);
    if (e_err == 2) check({tag, "_done_stays"}, done, 1);
    else wait_done(tag);
    finish_checks(tag, e_err, e_idx);
  endtask

  initial begin
    int e_err, e_idx, base, snap;
    for (int i = 0; i < NE; i++) begin model_tbl[i] = '0; nack_plan[i] = 0; end
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_done", done, 1);
    check("rst_err", err_code, 0);
    check("rst_err_idx", error_index, 0);
    check("rst_cur_idx", cur_index, 0);
    check("rst_ser_start", ser_start, 0);
    check("rst_ser_data", ser_data, 0);
    rst_n = 1'b1;

    // Basic four-entry sequence and Start-to-Ser_start latency.
    for (int i = 0; i < 4; i++) write_tbl(i, 16'h4501 + 16'(i));
    for (int i = 17; i < 20; i++) write_tbl(i, 16'hC000 + 16'(i));
    plan_seq(0, 4, e_err, e_idx);
    pulse_start(0, 4, 1'b0, 1'b0, 0, '0);
    check("lat_busy", done, 0);
    check("lat_no_start_yet", ser_start, 0);
    @(posedge clk); #1;
    check("lat_ser_start_2cyc", ser_start, 1);
    wait_done("basic");
    finish_checks("basic", e_err, e_idx);
    check("ser_data_hold", ser_data, 16'h4504);

    // Retries that eventually succeed, then retries exhausted.
    nack_plan[2] = 2;
    run_seq("retry_ok", 0, 4);
    nack_plan[2] = 9;
    run_seq("retry_fail", 0, 4);
    nack_plan[2] = 0;

    // Range boundaries.
    run_seq("range_18_3", 18, 3);
    run_seq("range_cnt0", 3, 0);
    run_seq("range_idx20", 20, 1);
    run_seq("range_17_3", 17, 3);

    // Abort while a frame is in flight: frame completes, nothing more sent.
    push_exp(0, 1'b1); push_exp(1, 1'b1);
    base = sends;
    pulse_start(0, 4, 1'b0, 1'b0, 0, '0);
    wait_sends(base + 2, "abort_wd");
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abort_wd");
    finish_checks("abort_wd", 3, 1);

    // Abort during the inter-frame gap stops on the next edge.
    push_exp(0, 1'b1);
    base = done_rises;
    pulse_start(0, 4, 1'b0, 1'b0, 0, '0);
    for (int i = 0; i < 500 && done_rises <= base; i++) @(posedge clk);
    check("abort_gap_reach", done_rises > base, 1);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    check("abort_gap_done", done, 1);
    @(negedge clk);
    abort = 1'b0;
    snap = sends;
    repeat (20) @(negedge clk);
    check("abort_gap_no_more", sends, snap);
    finish_checks("abort_gap", 3, 1);

    // Table write together with Start (and a simultaneous Abort) in idle.
    model_tbl[6] = 16'hA006;
    plan_seq(6, 1, e_err, e_idx);
    pulse_start(6, 1, 1'b1, 1'b1, 6, 16'hA006);
    wait_done("we_with_start");
    finish_checks("we_with_start", e_err, e_idx);

    // Writes and Start while busy are ignored.
    plan_seq(0, 2, e_err, e_idx);
    base = sends;
    pulse_start(0, 2, 1'b0, 1'b0, 0, '0);
    wait_sends(base + 1, "busy_write");
    @(negedge clk);
    tbl_we = 1'b1; tbl_addr = 5'd1; tbl_wdata = 16'hBEEF;
    start = 1'b1; start_index = 5'd5; count = 6'd1;
    @(negedge clk);
    tbl_we = 1'b0; start = 1'b0;
    wait_done("busy_write");
    finish_checks("busy_write", e_err, e_idx);
    run_seq("readback_1", 1, 1);

    // Reset mid-sequence returns outputs to reset values and clears the table.
    plan_seq(0, 4, e_err, e_idx);
    base = sends;
    pulse_start(0, 4, 1'b0, 1'b0, 0, '0);
    wait_sends(base + 2, "reset_mid");
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_done", done, 1);
    check("mid_rst_err", err_code, 0);
    check("mid_rst_err_idx", error_index, 0);
    check("mid_rst_cur_idx", cur_index, 0);
    check("mid_rst_ser_start", ser_start, 0);
    check("mid_rst_ser_data", ser_data, 0);
    sb.delete();
    for (int i = 0; i < NE; i++) model_tbl[i] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_seq("after_reset", 0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
